// File: rtl/frame_timing_pkg.sv
// Frame timing package: FSM state encoding and derived timing constants.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package frame_timing_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      LEAD,
      ACTIVE,
      TRAIL,
      GAP,
      FGAP
   } state_t;

   // Cycles lval is high for one line.
   function automatic int line_cyc(input int lead, input int width, input int trail);
      return lead + width + trail;
   endfunction

   // Cycles from frame start until fval falls on the last line.
   function automatic int act_cyc(input int idle2fval, input int height,
                                  input int line, input int lval_low);
      return idle2fval + height * line + (height - 1) * lval_low;
   endfunction

   // Frame period in cycles: nominal rate period, stretched if the active part is longer.
   function automatic int frame_cyc(input int clk_period, input int fps, input int act);
      int nom;
      nom = 1_000_000_000 / (clk_period * fps);
      return (nom > act) ? nom : act;
   endfunction

   // Largest of four segment lengths; sizes the in-state cycle counter.
   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/frame_timing_gen.sv
// Camera-style frame timing generator: fval/lval/dval plus row/col pixel address.
// Latency: outputs are registered one cycle behind the FSM state; first fval T_IDLE2FVAL+1 cycles after en sampled.
// Backpressure: none; en is a level enable sampled only in IDLE and at frame-period end.
module frame_timing_gen
   import frame_timing_pkg::*;
#(
   parameter int CLK_PERIOD          = 8,
   parameter int FPS                 = 100,
   parameter int WIDTH               = 640,
   parameter int HEIGHT              = 480,
   parameter int T_IDLE2FVAL         = 8192,
   parameter int T_LVALHIGH_DVALHIGH = 16,
   parameter int T_DVALLOW_LVALLOW   = 16,
   parameter int T_LVALLOW           = 16
) (
   input  logic                       clk,
   input  logic                       rstb,
   input  logic                       en,
   output logic                       fval,
   output logic                       lval,
   output logic                       dval,
   output logic [$clog2(HEIGHT)-1:0]  row,
   output logic [$clog2(WIDTH)-1:0]   col
);

   localparam int LINE_CYC  = line_cyc(T_LVALHIGH_DVALHIGH, WIDTH, T_DVALLOW_LVALLOW);
   localparam int ACT_CYC   = act_cyc(T_IDLE2FVAL, HEIGHT, LINE_CYC, T_LVALLOW);
   localparam int FRAME_CYC = frame_cyc(CLK_PERIOD, FPS, ACT_CYC);

   localparam int PCNT_W = $clog2(FRAME_CYC + 1);
   localparam int SEG_MAX = max4(T_IDLE2FVAL, max4(T_LVALHIGH_DVALHIGH, WIDTH, T_DVALLOW_LVALLOW, T_LVALLOW),
                                 1, 1);
   localparam int SCNT_W = $clog2(SEG_MAX + 1);
   localparam int ROW_W  = $clog2(HEIGHT);
   localparam int COL_W  = $clog2(WIDTH);

   localparam logic [PCNT_W-1:0] FRAME_CYC_V = PCNT_W'(FRAME_CYC);
   localparam logic [SCNT_W-1:0] WAIT_LAST   = SCNT_W'(T_IDLE2FVAL - 1);
   localparam logic [SCNT_W-1:0] LEAD_LAST   = SCNT_W'(T_LVALHIGH_DVALHIGH - 1);
   localparam logic [SCNT_W-1:0] ACT_LAST    = SCNT_W'(WIDTH - 1);
   localparam logic [SCNT_W-1:0] TRAIL_LAST  = SCNT_W'(T_DVALLOW_LVALLOW - 1);
   localparam logic [SCNT_W-1:0] GAP_LAST    = SCNT_W'(T_LVALLOW - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(HEIGHT - 1);

   state_t              state;
   state_t              state_nxt;
   logic [SCNT_W-1:0]   scnt;      // cycles spent in the current timed state
   logic [PCNT_W-1:0]   pcnt;      // cycles elapsed since frame start
   logic [ROW_W-1:0]    row_cnt;
   logic                seg_done;
   logic                period_done;
   logic                last_row;
   logic                frame_start;

   assign period_done = (pcnt >= FRAME_CYC_V);
   assign last_row    = (row_cnt == ROW_LAST);
   assign frame_start = (state_nxt == WAIT) && (state != WAIT);

   // Decode end of the current fixed-length segment.
   always_comb begin
      seg_done = 1'b0;
      case (state)
         WAIT:    seg_done = (scnt == WAIT_LAST);
         LEAD:    seg_done = (scnt == LEAD_LAST);
         ACTIVE:  seg_done = (scnt == ACT_LAST);
         TRAIL:   seg_done = (scnt == TRAIL_LAST);
         GAP:     seg_done = (scnt == GAP_LAST);
         default: seg_done = 1'b0;
      endcase
   end

   // Next-state logic; the period check on the last line lets a frame with no
   // spare time restart directly without an extra FGAP cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = WAIT;
         WAIT:    if (seg_done) state_nxt = LEAD;
         LEAD:    if (seg_done) state_nxt = ACTIVE;
         ACTIVE:  if (seg_done) state_nxt = TRAIL;
         TRAIL: begin
            if (seg_done) begin
               if (!last_row)        state_nxt = GAP;
               else if (period_done) state_nxt = en ? WAIT : IDLE;
               else                  state_nxt = FGAP;
            end
         end
         GAP:     if (seg_done) state_nxt = LEAD;
         FGAP:    if (period_done) state_nxt = en ? WAIT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) state <= IDLE;
      else      state <= state_nxt;
   end

   // In-state cycle counter; restarts on every state change.
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb)                                               scnt <= '0;
      else if (state_nxt != state || state == IDLE || state == FGAP) scnt <= '0;
      else                                                    scnt <= scnt + 1'b1;
   end

   // Frame-period counter; reads 1 in the first WAIT cycle so FRAME_CYC marks the period end.
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb)                    pcnt <= '0;
      else if (frame_start)        pcnt <= PCNT_W'(1);
      else if (state_nxt == IDLE)  pcnt <= '0;
      else                         pcnt <= pcnt + 1'b1;
   end

   // Line index; advances when leaving the inter-line gap.
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb)                                row_cnt <= '0;
      else if (frame_start || state_nxt == IDLE) row_cnt <= '0;
      else if (state == GAP && state_nxt == LEAD) row_cnt <= row_cnt + 1'b1;
   end

   // Registered outputs decoded from the current state.
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         fval <= 1'b0;
         lval <= 1'b0;
         dval <= 1'b0;
         row  <= '0;
         col  <= '0;
      end else begin
         fval <= (state == LEAD) || (state == ACTIVE) || (state == TRAIL) || (state == GAP);
         lval <= (state == LEAD) || (state == ACTIVE) || (state == TRAIL);
         dval <= (state == ACTIVE);
         row  <= ((state == LEAD) || (state == ACTIVE) || (state == TRAIL) || (state == GAP))
                 ? row_cnt : '0;
         col  <= (state == ACTIVE) ? scnt[COL_W-1:0] : '0;
      end
   end

endmodule

// File: tb/tb_frame_timing_gen.sv
// Directed bench for frame_timing_gen with small timing parameters.
// Pixel order is scoreboarded; edge times are logged by a monitor and checked in the main sequence.
// Inputs are driven 2 time units after posedge; outputs are sampled on negedge.
module tb_frame_timing_gen;

   localparam int W = 8;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rstb;
   logic       en;
   logic       fval;
   logic       lval;
   logic       dval;
   logic [1:0] row;
   logic [2:0] col;

   always #5 clk = ~clk;

   frame_timing_gen #(
      .CLK_PERIOD(8), .FPS(1_000_000), .WIDTH(W), .HEIGHT(H), .T_IDLE2FVAL(5),
      .T_LVALHIGH_DVALHIGH(2), .T_DVALLOW_LVALLOW(3), .T_LVALLOW(2)
   ) dut (
      .clk(clk), .rstb(rstb), .en(en), .fval(fval), .lval(lval), .dval(dval),
      .row(row), .col(col)
   );

   typedef struct {
      int r;
      int c;
   } px_t;

   int  checks   = 0;
   int  failures = 0;
   int  cyc      = 0;
   int  dval_cnt = 0;
   int  en_edge  = 0;
   int  n        = 0;
   int  pulses   = 0;
   px_t exp_q[$];
   int  fr_q[$], ff_q[$], lr_q[$], lf_q[$], dr_q[$], df_q[$];
   logic pf = 1'b0, pl = 1'b0, pd = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic push_frame();
      px_t p;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            p.r = r;
            p.c = c;
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic clear_log();
      fr_q.delete(); ff_q.delete(); lr_q.delete();
      lf_q.delete(); dr_q.delete(); df_q.delete();
   endtask

   // Cycle counter: number of posedges so far.
   always @(posedge clk) cyc++;

   // Monitor: log edges, pop the scoreboard on each dval cycle, check idle address values.
   always @(negedge clk) begin
      px_t p;
      if (fval !== pf) begin if (fval === 1'b1) fr_q.push_back(cyc); else ff_q.push_back(cyc); end
      if (lval !== pl) begin if (lval === 1'b1) lr_q.push_back(cyc); else lf_q.push_back(cyc); end
      if (dval !== pd) begin if (dval === 1'b1) dr_q.push_back(cyc); else df_q.push_back(cyc); end
      pf = fval;
      pl = lval;
      pd = dval;
      if (dval === 1'b1) begin
         dval_cnt++;
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            p = exp_q.pop_front();
            chk("pix_row", row, p.r);
            chk("pix_col", col, p.c);
         end
      end else begin
         chk("col_idle", col, 0);
      end
      if (fval !== 1'b1) chk("row_idle", row, 0);
   end

   initial begin
      rstb = 1'b0;
      en   = 1'b1;
      #1 rstb = 1'b1;

      // Reset held with en high: everything stays low.
      repeat (3) @(posedge clk);
      #2;
      chk("rst_fval", fval, 0);
      chk("rst_lval", lval, 0);
      chk("rst_dval", dval, 0);
      chk("rst_row", row, 0);
      chk("rst_col", col, 0);

      // Run three frames back to back.
      clear_log();
      dval_cnt = 0;
      push_frame(); push_frame(); push_frame();
      rstb    = 1'b0;
      en_edge = cyc + 1;
      n = 0;
      while (fr_q.size() < 3 && n < 400) begin @(posedge clk); #2; n++; end
      chk("wait_three_frames", (fr_q.size() >= 3), 1);

      chk("en_to_fval", fr_q[0] - en_edge, 6);
      chk("fval_period_01", fr_q[1] - fr_q[0], 125);
      chk("fval_period_12", fr_q[2] - fr_q[1], 125);
      chk("fval_high_len", ff_q[0] - fr_q[0], 58);
      chk("fval_lval_rise", lr_q[0], fr_q[0]);
      chk("fval_lval_fall", ff_q[0], lf_q[3]);
      for (int k = 0; k < H; k++) begin
         chk("lval_len", lf_q[k] - lr_q[k], 13);
         chk("lval_to_dval", dr_q[k] - lr_q[k], 2);
         chk("dval_len", df_q[k] - dr_q[k], 8);
         chk("dval_to_lval_fall", lf_q[k] - df_q[k], 3);
         if (k < H - 1) chk("lval_gap", lr_q[k + 1] - lf_q[k], 2);
      end
      pulses = 0;
      foreach (lr_q[i]) if (lr_q[i] >= fr_q[0] && lr_q[i] < fr_q[1]) pulses++;
      chk("lval_pulses_f0", pulses, 4);

      // Drop en in the middle of line 1 of the third frame; that frame must finish.
      n = 0;
      while (!(dval === 1'b1 && row == 2'd1) && n < 100) begin @(posedge clk); #2; n++; end
      chk("wait_mid_frame", (dval === 1'b1 && row == 2'd1), 1);
      en = 1'b0;
      repeat (200) @(posedge clk);
      #2;
      chk("no_new_frame", fr_q.size(), 3);
      chk("dval_total", dval_cnt, 96);
      chk("sb_drained", exp_q.size(), 0);
      chk("last_frame_len", ff_q[2] - fr_q[2], 58);
      chk("idle_fval", fval, 0);

      // Reset asserted mid-line clears outputs immediately.
      clear_log();
      dval_cnt = 0;
      push_frame();
      en = 1'b1;
      n = 0;
      while (!(dval === 1'b1 && col == 3'd3) && n < 100) begin @(posedge clk); #2; n++; end
      chk("wait_col3", (dval === 1'b1 && col == 3'd3), 1);
      chk("sb_consumed", exp_q.size(), 29);
      rstb = 1'b1;
      #1;
      chk("midrst_fval", fval, 0);
      chk("midrst_lval", lval, 0);
      chk("midrst_dval", dval, 0);
      chk("midrst_row", row, 0);
      chk("midrst_col", col, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #2;
      chk("rst_hold_fval", fval, 0);
      chk("rst_hold_dval", dval, 0);

      // Release reset with en low: generator stays idle.
      en   = 1'b0;
      rstb = 1'b0;
      clear_log();
      repeat (30) @(posedge clk);
      #2;
      chk("idle_no_rise", fr_q.size(), 0);
      chk("idle_fval_low", fval, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
